// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: register-file address/data widths and the
// writeback queue entry.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    // The destination field cannot be named "reg" because that is a keyword.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback queue with power-of-two depth. It exposes the per-slot
// valid bits and destination registers so the arbiter can run hazard lookups.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push,
    input  wb_entry_t                        push_entry,
    input  logic                             pop,
    output wb_entry_t                        head,
    output logic                             full,
    output logic                             empty,
    output logic [CNT_W-1:0]                 count,
    output logic [DEPTH-1:0]                 entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_reg
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] offset;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // NOTE: storage has no reset; slots are only read once the pointers say
    // they hold data, so clearing them would buy nothing.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        entry_valid = '0;
        entry_reg   = '0;
        offset      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset         = PTR_W'(i) - rd_ptr;
            entry_valid[i] = (CNT_W'(offset) < count);
            entry_reg[i]   = mem[i].rd;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: the load unit has fixed priority over the ALU, requests
// are queued in order, and one register-file write is issued per cycle.
// Optional macro WB_R0_DISCARD_EN accepts but drops writes to register 0.
module wb_arbiter
    import riscv_pkg::*;
#(
    parameter int WB_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0]     mem_data,
    output logic                  mem_ready,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0]     alu_data,
    output logic                  alu_ready,
    output logic                  regWrite,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0]     writeData,
    input  logic [REG_ADDR_W-1:0] query_reg,
    output logic                  query_pending
);

    localparam int CNT_W = $clog2(WB_DEPTH + 1);

    logic                                full;
    logic                                empty;
    logic                                accept;
    logic                                push;
    logic                                pop;
    wb_entry_t                           push_entry;
    wb_entry_t                           head;
    logic [CNT_W-1:0]                    count;
    logic [WB_DEPTH-1:0]                 entry_valid;
    logic [WB_DEPTH-1:0][REG_ADDR_W-1:0] entry_reg;

    // Readiness looks only at occupancy, never at a same-cycle pop.
    assign mem_ready = !full;
    assign alu_ready = !full && !mem_valid;

    assign accept     = (mem_valid && mem_ready) || (alu_valid && alu_ready);
    assign push_entry = mem_valid ? wb_entry_t'{rd: mem_reg, data: mem_data}
                                  : wb_entry_t'{rd: alu_reg, data: alu_data};
`ifdef WB_R0_DISCARD_EN
    assign push = accept && (push_entry.rd != '0);
`else
    assign push = accept;
`endif
    assign pop = !empty;

    wb_fifo #(.DEPTH(WB_DEPTH)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head        (head),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .entry_valid (entry_valid),
        .entry_reg   (entry_reg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            regWrite  <= 1'b0;
            write_reg <= '0;
            writeData <= '0;
        end else begin
            regWrite <= pop;
            if (pop) begin
                write_reg <= head.rd;
                writeData <= head.data;
            end
        end
    end

    always_comb begin
        query_pending = regWrite && (write_reg == query_reg);
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (entry_valid[i] && (entry_reg[i] == query_reg)) query_pending = 1'b1;
        end
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter WB_DEPTH, default 4, number of writeback queue entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports mem_valid/mem_reg/mem_data  input  1/5/32  load-unit writeback request: valid, destination register, data.
REQ-005 SHALL have port mem_ready  output  1  load-unit request accepted when mem_valid && mem_ready at posedge clk.
REQ-006 SHALL have ports alu_valid/alu_reg/alu_data  input  1/5/32  ALU writeback request: valid, destination register, data.
REQ-007 SHALL have port alu_ready  output  1  ALU request accepted when alu_valid && alu_ready at posedge clk.
REQ-008 SHALL have ports regWrite/write_reg/writeData  output  1/5/32  register-file write port, all driven from flops.
REQ-009 SHALL have ports query_reg  input  5  and query_pending  output  1  hazard lookup: destination still in flight.

Function
REQ-010 SHALL hold an in-order FIFO of WB_DEPTH entries {reg, data}, occupancy count 0..WB_DEPTH.
REQ-011 SHALL give the load unit fixed priority: mem_ready = !full; alu_ready = !full && !mem_valid.
REQ-012 SHALL push at most one entry per cycle; ready SHALL NOT depend on a same-cycle pop (full rejects even if popping).
REQ-013 SHALL, each cycle the FIFO is non-empty, pop the head into the output register: regWrite=1, write_reg/writeData=head next cycle.
REQ-014 SHALL drive regWrite=0 in any cycle following an empty-FIFO cycle; write_reg/writeData hold last value.
REQ-015 SHALL have latency: request accepted at edge k -> regWrite high from edge k+1 to k+2 -> register file writes at edge k+2.
REQ-016 SHALL allow simultaneous push and pop; count unchanged; empty FIFO with push SHALL NOT bypass (pop starts next cycle).
REQ-017 SHALL wrap read/write pointers modulo WB_DEPTH without loss or reordering.
REQ-018 SHALL assert query_pending combinationally when query_reg matches any valid FIFO entry or write_reg while regWrite=1.
REQ-019 SHALL sustain one write per cycle when requests arrive every cycle; the FIFO never fills under that load.

Reset
REQ-020 SHALL, on reset high at posedge clk, clear count and pointers; regWrite=0, write_reg=0, writeData=0.
REQ-021 SHALL discard queued and in-flight entries when reset is asserted mid-operation; reset overrides same-cycle push.
REQ-022 SHALL drive mem_ready=1, alu_ready=!mem_valid, query_pending=0 in the cycle after reset.

Configuration
REQ-023 SHALL support macro WB_R0_DISCARD_EN: when defined, requests with reg==0 are accepted (ready handshake unchanged) but never pushed, produce no regWrite, and never set query_pending.
REQ-024 SHALL, without WB_R0_DISCARD_EN, queue and write register 0 like any other register.

Structure
REQ-025 SHALL take REG_ADDR_W=5, DATA_W=32 and typedef wb_entry_t {reg, data} from shared package riscv_pkg.
REQ-026 SHALL implement the queue as sub-module wb_fifo (push/pop/full/empty/count plus per-entry valid/reg outputs for the hazard compare).

Verification
REQ-027 SHALL verify single request: alu_valid, alu_reg=5, alu_data=0xDEADBEEF at edge 0 -> regWrite=1, write_reg=5, writeData=0xDEADBEEF after edge 1 only.
REQ-028 SHALL verify priority: mem(reg=3,0x11) and alu(reg=4,0x22) both valid -> alu_ready=0; mem written first; alu written after mem_valid drops.
REQ-029 SHALL verify full: 4 pushes with output stalled impossible -> drive 5 back-to-back mem pushes while tracking count; mem_ready=0 exactly when count=4, no loss, order preserved across pointer wrap.
REQ-030 SHALL verify hazard: queue reg=7 -> query_reg=7 gives query_pending=1 until the cycle after its regWrite pulse, query_reg=8 gives 0.
REQ-031 SHALL verify reset mid-op: 3 entries queued, reset one cycle -> regWrite=0, count=0, no queued write appears afterwards.
REQ-032 SHALL verify WB_R0_DISCARD_EN: alu_reg=0, alu_data=0x1 -> alu_ready=1, no regWrite pulse when defined; pulse with write_reg=0 when undefined.
